demux_1x2_stream: RTL and testbench

- Sequential 1-to-2 stream demultiplexer; the counterpart of the lab 2:1 mux, fanning one input stream out to two outputs.
- Each input beat is steered by `in_sel` into one of two independent per-output FIFOs.
- Each output drains under its own valid/ready handshake.
- Used in the seminar labs as the next step after combinational muxing: handshakes, buffering, back-pressure.

---
 rtl/demux_1x2_stream.sv | 102 ++++++++++
 tb/tb_demux_1x2_stream.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/demux_1x2_stream.sv
// 1-to-2 stream demultiplexer: in_sel steers each beat into one of two
// independent FIFOs. Define DEMUX_CNT_EN to add per-output delivered-beat counters.
module demux_1x2_stream #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [DATA_W-1:0] in_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0]  out0_cnt,
    output logic [CNT_W-1:0]  out1_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [2][DEPTH];
    logic [AW:0]       wptr [2];
    logic [AW:0]       rptr [2];
    logic [DATA_W-1:0] head [2];
    logic [1:0]        full;
    logic [1:0]        empty;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [1:0]        rdy;

    // One extra pointer bit distinguishes full from empty when the indices match.
    function automatic logic ptr_full(input logic [AW:0] w, input logic [AW:0] r);
        return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
    endfunction

    function automatic logic ptr_empty(input logic [AW:0] w, input logic [AW:0] r);
        return w == r;
    endfunction

    assign rdy      = {out1_ready, out0_ready};
    assign in_ready = ~full[in_sel];

    always_comb begin
        full  = '0;
        empty = '0;
        push  = '0;
        pop   = '0;
        head  = '{default: '0};
        for (int k = 0; k < 2; k++) begin
            full[k]  = ptr_full(wptr[k], rptr[k]);
            empty[k] = ptr_empty(wptr[k], rptr[k]);
            push[k]  = in_valid && !full[k] && (in_sel == 1'(k)) && !rst;
            pop[k]   = !empty[k] && rdy[k] && !rst;
            head[k]  = empty[k] ? '0 : mem[k][rptr[k][AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '{default: '0};
            rptr <= '{default: '0};
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) wptr[k] <= wptr[k] + 1'b1;
                if (pop[k])  rptr[k] <= rptr[k] + 1'b1;
            end
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (push[k]) mem[k][wptr[k][AW-1:0]] <= in_data;
        end
    end

    assign out0_valid = ~empty[0];
    assign out1_valid = ~empty[1];
    assign out0_data  = head[0];
    assign out1_data  = head[1];

`ifdef DEMUX_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out0_cnt <= '0;
            out1_cnt <= '0;
        end else begin
            if (pop[0]) out0_cnt <= out0_cnt + 1'b1;
            if (pop[1]) out1_cnt <= out1_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Scoreboard bench for demux_1x2_stream: per-output expected queues are filled
// on acceptance and compared against the DUT head every cycle.
module tb_demux_1x2_stream;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_sel = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out0_valid;
    logic              out0_ready = 1'b0;
    logic [DATA_W-1:0] out0_data;
    logic              out1_valid;
    logic              out1_ready = 1'b0;
    logic [DATA_W-1:0] out1_data;
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0]  out0_cnt;
    logic [CNT_W-1:0]  out1_cnt;
`endif

    demux_1x2_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef DEMUX_CNT_EN
        ,
        .out0_cnt   (out0_cnt),
        .out1_cnt   (out1_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] q0 [$];
    logic [DATA_W-1:0] q1 [$];
    logic [CNT_W-1:0]  cnt0 = '0;
    logic [CNT_W-1:0]  cnt1 = '0;
    int                n_checks = 0;
    int                n_fail = 0;
    logic              tog = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare against the model, then advance the model.
    task automatic cycle(input logic v, input logic s, input logic [DATA_W-1:0] d,
                         input logic r0, input logic r1, output logic acc);
        logic rdy_m, p0, p1;
        in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
        #1;
        rdy_m = (s ? q1.size() : q0.size()) < DEPTH;
        chk("in_ready", in_ready, rdy_m);
        chk("out0_valid", out0_valid, q0.size() != 0);
        chk("out0_data", out0_data, (q0.size() != 0) ? q0[0] : 8'h00);
        chk("out1_valid", out1_valid, q1.size() != 0);
        chk("out1_data", out1_data, (q1.size() != 0) ? q1[0] : 8'h00);
`ifdef DEMUX_CNT_EN
        chk("out0_cnt", out0_cnt, cnt0);
        chk("out1_cnt", out1_cnt, cnt1);
`endif
        acc = v && rdy_m && !rst;
        p0  = r0 && (q0.size() != 0) && !rst;
        p1  = r1 && (q1.size() != 0) && !rst;
        @(posedge clk);
        if (rst) begin
            q0.delete(); q1.delete(); cnt0 = '0; cnt1 = '0;
        end else begin
            if (p0) begin void'(q0.pop_front()); cnt0++; end
            if (p1) begin void'(q1.pop_front()); cnt1++; end
            if (acc) begin
                if (s) q1.push_back(d);
                else   q0.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    // Holds a beat until the model accepts it; tg makes out0_ready toggle each cycle.
    task automatic send(input logic s, input logic [DATA_W-1:0] d,
                        input logic r0, input logic r1, input logic tg);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            if (tg) tog = ~tog;
            cycle(1'b1, s, d, tg ? tog : r0, r1, acc);
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input logic r0, input logic r1);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, r0, r1, acc);
    endtask

    task automatic do_reset();
        logic acc;
        rst = 1'b1;
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        rst = 1'b0;
    endtask

    initial begin
        logic acc;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset: ready, nothing valid, data zero.
        idle(1, 1'b0, 1'b0);

        // Single beats to each output, consumers ready.
        send(1'b0, 8'hA5, 1'b1, 1'b1, 1'b0);
        send(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b1);

        // Fill out0 under back-pressure while out1 keeps flowing.
        for (int i = 1; i <= 4; i++) send(1'b0, 8'(i), 1'b0, 1'b1, 1'b0);
        send(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 8'h05, 1'b0, 1'b1, acc);
        chk("full_stall", {31'd0, acc}, 32'd0);
        cycle(1'b1, 1'b0, 8'h05, 1'b1, 1'b1, acc);
        chk("no_passthru", {31'd0, acc}, 32'd0);
        send(1'b0, 8'h05, 1'b1, 1'b1, 1'b0);
        idle(6, 1'b1, 1'b1);

        // Streaming across pointer wrap with toggling out0_ready.
        do_reset();
        for (int i = 0; i < 20; i++) send(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
        idle(8, 1'b1, 1'b1);
        chk("stream_q0_empty", q0.size(), 32'd0);
`ifdef DEMUX_CNT_EN
        chk("stream_cnt0", out0_cnt, 32'd20);
        chk("stream_cnt1", out1_cnt, 32'd0);
`endif

        // Reset with out1 partially full, then a lone beat.
        for (int i = 0; i < 3; i++) send(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
        do_reset();
        #1;
        chk("rst_out1_valid", out1_valid, 32'd0);
        chk("rst_out1_data", out1_data, 32'd0);
`ifdef DEMUX_CNT_EN
        chk("rst_out1_cnt", out1_cnt, 32'd0);
`endif
        send(1'b1, 8'h9E, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
